jk_sync_counter: RTL and testbench
==================================

Name: jk_sync_counter

Overview:
- Synchronous up/down modulo-N counter built from a bank of JK flip-flops with asynchronous active-low reset.
- Sits directly downstream of the JK flip-flop stage and consumes it as its storage element.
- Each bit's J/K pair is driven from computed next-state logic.
- Provides load, enable, direction, a terminal-count flag and a registered wrap pulse for cascading or driving timing logic.

Parameters:
- WIDTH, 4, counter width in bits (2..16).
- MODULUS, 16, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.

Ports:
- clock  input  1  single system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  count enable.
- up_down  input  1  direction: 1 = up, 0 = down.
- load  input  1  synchronous parallel load strobe.
- load_value  input  WIDTH  value to load.
- count  output  WIDTH  current count (Q of the flip-flop bank).
- terminal_count  output  1  combinational; high when enable=1, load=0 and count is at the direction's limit (MODULUS-1 when up, 0 when down).
- wrap_pulse  output  1  registered; high for exactly one cycle after a wrap.

Behaviour:
- Interface: one clock, named clock. Reset is asynchronous and active-low, named reset.
- Reset: reset=0 forces count=0 and wrap_pulse=0 immediately, independent of clock.
  - Reset release is synchronous to the next rising edge of clock.
  - Reset asserted mid-count aborts the count; no wrap_pulse is generated.
- Priority per rising edge: reset > load > enable > hold.
- Load:
  - load=1: count <= load_value.
  - If load_value >= MODULUS, count <= MODULUS-1 (clamped).
  - Load ignores enable and up_down; wrap_pulse <= 0.
- Count:
  - enable=1, load=0, up: count <= count+1. From MODULUS-1, count <= 0.
  - enable=1, load=0, down: count <= count-1. From 0, count <= MODULUS-1.
- Hold: enable=0, load=0 leaves count unchanged and sets wrap_pulse <= 0.
- Wrap: wrap_pulse <= 1 on the edge where a wrap occurs, otherwise 0. It is high in the cycle where count shows the wrapped value.
- Direction change: takes effect on the same edge it is sampled; no pipeline delay. A direction flip while at a limit uses the new direction's limit.
- Latency: one cycle from enable/load to count. terminal_count has zero latency and is purely combinational from count, enable, load and up_down.
- JK drive per bit i, with n = computed next state:
  - J_i = n_i & ~q_i
  - K_i = ~n_i & q_i
  - J=K=0 when the bit holds. J=K=1 is never produced.
- Arithmetic is WIDTH bits; the internal comparison uses WIDTH+1 bits so that MODULUS = 2**WIDTH is representable.

Optional Feature:
- Macro: JK_COUNTER_SATURATE_EN.
- Defined:
  - Counting stops at the limit: up holds at MODULUS-1, down holds at 0.
  - wrap_pulse is tied to 0.
  - terminal_count still asserts at the limit.
- Undefined: wrap-around behaviour as described above.

Decomposition:
- Shared package jk_counter_pkg:
  - Localparam for direction encoding (DIR_UP=1, DIR_DOWN=0).
  - Function clamp_load(value, modulus).
  - Function next_count(count, up_down, modulus), with the saturating variant selected by the macro.
- One sub-module, jk_flipflop_ar: a JK flip-flop with async active-low reset and ports clock, reset, J, K, Q, Qnot.
  - Semantics: 00 hold, 01 reset, 10 set, 11 toggle.
  - Instantiated WIDTH times via generate.

Test Plan:
- Async reset: count=9, drop reset between edges -> count=0 within the same cycle, wrap_pulse=0; release then enable/up -> 1 after one edge.
- Up wrap, MODULUS=10, enable=1, up_down=1, from 0 -> 0..9, then 0.
  - terminal_count=1 while count=9.
  - wrap_pulse=1 only in the cycle showing 0.
- Down wrap from 2 -> 1, 0, 9; wrap_pulse=1 while count=9; terminal_count=1 at 0.
- Load priority: load=1, enable=1, load_value=5 -> count=5.
  - load_value=13 with MODULUS=10 -> count=9.
  - terminal_count=0 during load.
- Hold/direction: enable=0 for 3 cycles at 7 -> count stays 7. Flip up_down at count=9 -> next count 8, no wrap_pulse.
- JK_COUNTER_SATURATE_EN defined, MODULUS=10: up from 8 -> 9, 9, 9; down from 1 -> 0, 0; wrap_pulse always 0.

Source files
------------

// File: rtl/jk_counter_pkg.sv
// rtl/jk_counter_pkg.sv - shared constants and next-state helpers for the JK modulo counter
// Optional feature macro: JK_COUNTER_SATURATE_EN (saturating next_count variant)
package jk_counter_pkg;

    localparam int MAX_W = 16;
    localparam int CNT_W = MAX_W + 1;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    // CNT_W is one bit wider than the widest counter so a modulus of 2**WIDTH fits.
    function automatic logic [CNT_W-1:0] clamp_load(
        input logic [CNT_W-1:0] value,
        input logic [CNT_W-1:0] modulus
    );
        return (value >= modulus) ? (modulus - CNT_ONE) : value;
    endfunction

    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] count,
        input logic             up_down,
        input logic [CNT_W-1:0] modulus
    );
        logic [CNT_W-1:0] result;
        result = count;
`ifdef JK_COUNTER_SATURATE_EN
        if (up_down == DIR_UP) begin
            if (count != modulus - CNT_ONE) result = count + CNT_ONE;
        end else begin
            if (count != CNT_ZERO) result = count - CNT_ONE;
        end
`else
        if (up_down == DIR_UP) begin
            result = (count == modulus - CNT_ONE) ? CNT_ZERO : count + CNT_ONE;
        end else begin
            result = (count == CNT_ZERO) ? modulus - CNT_ONE : count - CNT_ONE;
        end
`endif
        return result;
    endfunction

endpackage

// File: rtl/jk_flipflop_ar.sv
// rtl/jk_flipflop_ar.sv - JK flip-flop with asynchronous active-low reset
module jk_flipflop_ar (
    input  logic clock,
    input  logic reset,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Qnot
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            Q <= 1'b0;
        end else begin
            case ({J, K})
                2'b01:   Q <= 1'b0;
                2'b10:   Q <= 1'b1;
                2'b11:   Q <= ~Q;
                default: Q <= Q;
            endcase
        end
    end

    assign Qnot = ~Q;

endmodule

// File: rtl/jk_sync_counter.sv
// rtl/jk_sync_counter.sv - up/down modulo-N counter on a bank of JK flip-flops
// Optional feature macro: JK_COUNTER_SATURATE_EN (hold at the limit, wrap_pulse tied low)
module jk_sync_counter
    import jk_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             terminal_count,
    output logic             wrap_pulse
);

    localparam logic [CNT_W-1:0] MOD_EXT = CNT_W'(MODULUS);

    logic [CNT_W-1:0] count_ext;
    logic [CNT_W-1:0] load_ext;
    logic [CNT_W-1:0] clamped;
    logic [CNT_W-1:0] stepped;
    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] j_bus;
    logic [WIDTH-1:0] k_bus;
    logic [WIDTH-1:0] qnot_bus;
    logic             at_limit;

    assign count_ext = {{(CNT_W-WIDTH){1'b0}}, count};
    assign load_ext  = {{(CNT_W-WIDTH){1'b0}}, load_value};

    assign at_limit = (up_down == DIR_UP) ? (count_ext == MOD_EXT - CNT_ONE)
                                          : (count_ext == CNT_ZERO);
    assign terminal_count = enable & ~load & at_limit;

    always_comb begin
        clamped = clamp_load(load_ext, MOD_EXT);
        stepped = next_count(count_ext, up_down, MOD_EXT);
        next_q  = count;
        if (load) begin
            next_q = clamped[WIDTH-1:0];
        end else if (enable) begin
            next_q = stepped[WIDTH-1:0];
        end
    end

    // Set only bits rising 0->1, clear only bits falling 1->0; J=K=1 can never occur.
    assign j_bus = next_q & qnot_bus;
    assign k_bus = ~next_q & count;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_flipflop_ar u_ff (
            .clock (clock),
            .reset (reset),
            .J     (j_bus[i]),
            .K     (k_bus[i]),
            .Q     (count[i]),
            .Qnot  (qnot_bus[i])
        );
    end

`ifdef JK_COUNTER_SATURATE_EN
    assign wrap_pulse = 1'b0;
`else
    // A wrap happens exactly on an enabled, non-load edge taken from the limit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= terminal_count;
        end
    end
`endif

endmodule

// File: tb/tb_jk_sync_counter.sv
// tb/tb_jk_sync_counter.sv - self-checking bench for jk_sync_counter (WIDTH=4, MODULUS=10)
module tb_jk_sync_counter;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;
`ifdef JK_COUNTER_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] cnt;
        logic             wrap;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic             up_down;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count;
    logic             terminal_count;
    logic             wrap_pulse;

    int   errors = 0;
    int   checks = 0;
    int   m = 0;
    exp_t sb[$];

    jk_sync_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .up_down        (up_down),
        .load           (load),
        .load_value     (load_value),
        .count          (count),
        .terminal_count (terminal_count),
        .wrap_pulse     (wrap_pulse)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step(input logic en, input logic ud, input logic ld, input int lv);
        exp_t e;
        int   nm;
        logic w;
        @(negedge clock);
        enable = en; up_down = ud; load = ld; load_value = WIDTH'(lv);
        #1;
        chk("terminal_count", 16'(terminal_count),
            16'(en && !ld && (ud ? (m == MODULUS - 1) : (m == 0))));
        nm = m;
        w  = 1'b0;
        if (ld) begin
            nm = (lv >= MODULUS) ? MODULUS - 1 : lv;
        end else if (en && ud) begin
            if (m == MODULUS - 1) begin
                nm = SAT ? m : 0;
                w  = !SAT;
            end else nm = m + 1;
        end else if (en) begin
            if (m == 0) begin
                nm = SAT ? 0 : MODULUS - 1;
                w  = !SAT;
            end else nm = m - 1;
        end
        m = nm;
        e.cnt  = WIDTH'(nm);
        e.wrap = w;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk("count", 16'(count), 16'(e.cnt));
        chk("wrap_pulse", 16'(wrap_pulse), 16'(e.wrap));
    endtask

    task automatic mid_cycle_reset();
        #2;
        reset = 1'b0; enable = 1'b0; load = 1'b0;
        #1;
        chk("async_reset_count", 16'(count), 16'd0);
        chk("async_reset_wrap", 16'(wrap_pulse), 16'd0);
        m = 0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; enable = 1'b0; up_down = 1'b1; load = 1'b0; load_value = '0;
        #12;
        chk("reset_count", 16'(count), 16'd0);
        chk("reset_wrap", 16'(wrap_pulse), 16'd0);
        chk("reset_tc", 16'(terminal_count), 16'd0);
        @(negedge clock);
        reset = 1'b1;
        m = 0;

        for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 0);   // 1..9, 0 (wrap), 1, 2
        for (int i = 0; i < 4; i++)  step(1'b1, 1'b0, 1'b0, 0);   // 1, 0, 9 (wrap), 8

        step(1'b0, 1'b0, 1'b1, 7);
        for (int i = 0; i < 3; i++)  step(1'b0, 1'b1, 1'b0, 0);   // hold at 7
        step(1'b0, 1'b1, 1'b1, 9);
        step(1'b1, 1'b0, 1'b0, 0);                                // flip at 9 -> 8, no wrap

        step(1'b1, 1'b1, 1'b1, 5);
        step(1'b1, 1'b0, 1'b1, 13);
        step(1'b0, 1'b1, 1'b1, 15);
        step(1'b1, 1'b1, 1'b1, 0);
        chk("load_clamp_zero", 16'(count), 16'd0);

        step(1'b0, 1'b1, 1'b1, 9);
        mid_cycle_reset();
        step(1'b1, 1'b1, 1'b0, 0);
        chk("release_first_up", 16'(count), 16'd1);

        step(1'b0, 1'b1, 1'b1, 9);
        step(1'b1, 1'b1, 1'b0, 0);                                // wrap pulse active
        mid_cycle_reset();

        step(1'b0, 1'b1, 1'b1, 8);
        for (int i = 0; i < 3; i++)  step(1'b1, 1'b1, 1'b0, 0);
        step(1'b0, 1'b0, 1'b1, 1);
        for (int i = 0; i < 2; i++)  step(1'b1, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
